// File: rtl/lvg_store_pkg.sv
// Shared definitions for the lvg writeback store: drain FSM encoding, matrix
// geometry (4x4 words, 16 beats per matrix), word size in bytes, and the
// per-beat byte offset helper used by the address generator.
package lvg_store_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } st_e;

  localparam int unsigned MAT_N      = 4;
  localparam int unsigned BEATS      = MAT_N * MAT_N;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = $clog2(BEATS);

  // Byte offset of beat k inside a matrix: row-major, row = k / MAT_N,
  // column = k % MAT_N. Callers truncate to the address width, so a base
  // near the top of the address space wraps silently.
  function automatic int unsigned beat_offset(input logic [IDX_W-1:0] k,
                                              input int unsigned      stride);
    int unsigned r;
    int unsigned c;
    r = 32'(k) / MAT_N;
    c = 32'(k) % MAT_N;
    return r * stride + c * WORD_BYTES;
  endfunction

endpackage

// File: rtl/lvg_store_if.sv
// Memory write port of the lvg store: valid/ready beats carrying a byte
// address and one data word. master = lvg_store, slave = memory side.
// Ports: wr_valid, wr_addr, wr_data (master -> slave), wr_ready (slave -> master).
interface lvg_store_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/lvg_store_bank.sv
// One ping-pong bank: 16 result words plus the destination base address.
// Latency: written on the capture edge, read combinationally by beat index.
// Backpressure: none here; the top decides when a bank may be overwritten.
// Ports: i_clk, i_we (capture), i_base/i_words (capture data),
//        i_idx (beat index), o_word (indexed word), o_base (latched base).
module lvg_store_bank
  import lvg_store_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_base,
  input  logic [DW-1:0]    i_words [BEATS],
  input  logic [IDX_W-1:0] i_idx,
  output logic [DW-1:0]    o_word,
  output logic [AW-1:0]    o_base
);

  logic [DW-1:0] r_words [BEATS];
  logic [AW-1:0] r_base;

  // Contents need no reset: they are only observed while the bank is
  // marked occupied, and the top zeroes the port whenever it is not valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_words <= i_words;
      r_base  <= i_base;
    end
  end

  assign o_word = r_words[i_idx];
  assign o_base = r_base;

endmodule

// File: rtl/lvg_store.sv
// Writeback stage: snapshots the 4x4 lvg result into one of two ping-pong
// banks and streams it row-major over a valid/ready write port.
// Latency: first beat on the port the cycle after the capture edge; one beat per cycle.
// Backpressure: beats hold while wr_ready=0; a capture with both banks full is dropped (ovf).
// Ports: i_clk, i_rst (async, active low), i_cap/i_base/i_b11..i_b44 (capture),
//        i_clr_ovf, wr (write port, master), o_st_done, o_busy, o_full, o_ovf.
module lvg_store
  import lvg_store_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int ROW_STRIDE = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cap,
  input  logic [AW-1:0] i_base,
  input  logic [DW-1:0] i_b11, i_b12, i_b13, i_b14,
  input  logic [DW-1:0] i_b21, i_b22, i_b23, i_b24,
  input  logic [DW-1:0] i_b31, i_b32, i_b33, i_b34,
  input  logic [DW-1:0] i_b41, i_b42, i_b43, i_b44,
  input  logic          i_clr_ovf,
  lvg_store_if.master   wr,
  output logic          o_st_done,
  output logic          o_busy,
  output logic          o_full,
  output logic          o_ovf
);

  logic [DW-1:0]    w_words [BEATS];
  logic [1:0]       r_occ;
  logic             r_wp;
  logic             r_rp;
  logic [IDX_W-1:0] r_k;
  st_e              r_state;
  st_e              w_state_nxt;
  logic             r_ovf;
  logic             r_st_done;

  logic             w_cap_acc;
  logic             w_cap_drop;
  logic             w_valid;
  logic             w_hs;
  logic             w_last;
  logic [DW-1:0]    w_word0, w_word1, w_rd_word;
  logic [AW-1:0]    w_base0, w_base1, w_rd_base;
  logic [AW-1:0]    w_addr;

  assign w_words[0]  = i_b11;  assign w_words[1]  = i_b12;
  assign w_words[2]  = i_b13;  assign w_words[3]  = i_b14;
  assign w_words[4]  = i_b21;  assign w_words[5]  = i_b22;
  assign w_words[6]  = i_b23;  assign w_words[7]  = i_b24;
  assign w_words[8]  = i_b31;  assign w_words[9]  = i_b32;
  assign w_words[10] = i_b33;  assign w_words[11] = i_b34;
  assign w_words[12] = i_b41;  assign w_words[13] = i_b42;
  assign w_words[14] = i_b43;  assign w_words[15] = i_b44;

  // Banks fill in wp order and drain in rp order, so the wp bank is
  // occupied only when both are. Deciding on the pre-edge flag means a
  // bank freeing on this same edge does not rescue the capture.
  assign w_cap_acc  = i_cap & ~r_occ[r_wp];
  assign w_cap_drop = i_cap &  r_occ[r_wp];

  assign w_valid = (r_state == ST_DRAIN);
  assign w_hs    = w_valid & wr.wr_ready;
  assign w_last  = w_hs & (r_k == IDX_W'(BEATS - 1));

  lvg_store_bank #(.DW(DW), .AW(AW)) u_bank0 (
    .i_clk   (i_clk),
    .i_we    (w_cap_acc & ~r_wp),
    .i_base  (i_base),
    .i_words (w_words),
    .i_idx   (r_k),
    .o_word  (w_word0),
    .o_base  (w_base0)
  );

  lvg_store_bank #(.DW(DW), .AW(AW)) u_bank1 (
    .i_clk   (i_clk),
    .i_we    (w_cap_acc & r_wp),
    .i_base  (i_base),
    .i_words (w_words),
    .i_idx   (r_k),
    .o_word  (w_word1),
    .o_base  (w_base1)
  );

  assign w_rd_word = r_rp ? w_word1 : w_word0;
  assign w_rd_base = r_rp ? w_base1 : w_base0;
  assign w_addr    = w_rd_base + AW'(beat_offset(r_k, unsigned'(ROW_STRIDE)));

  // Zeroed when idle so the port is quiet (and defined) outside a drain.
  assign wr.wr_valid = w_valid;
  assign wr.wr_addr  = w_valid ? w_addr    : '0;
  assign wr.wr_data  = w_valid ? w_rd_word : '0;

  // In IDLE no bank is occupied and wp == rp, so an accepted capture lands
  // in the rp bank and the drain can start on the capture edge itself.
  // In DRAIN an accepted capture always lands in the other bank, which lets
  // the next matrix follow beat 15 without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_occ[r_rp] || w_cap_acc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_last && !(r_occ[~r_rp] || w_cap_acc)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_occ     <= 2'b00;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_k       <= '0;
      r_ovf     <= 1'b0;
      r_st_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_st_done <= w_last;

      // w_last frees the rp bank, w_cap_acc fills the (distinct) wp bank.
      if (w_last)    r_occ[r_rp] <= 1'b0;
      if (w_cap_acc) r_occ[r_wp] <= 1'b1;

      if (w_cap_acc) r_wp <= ~r_wp;
      if (w_last)    r_rp <= ~r_rp;

      // k wraps from 15 to 0 naturally at the final beat.
      if (w_hs) r_k <= r_k + 1'b1;

      if (w_cap_drop)     r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign o_st_done = r_st_done;
  assign o_busy    = |r_occ;
  assign o_full    = &r_occ;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_lvg_store.sv
module tb_lvg_store;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int RS = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [DW-1:0] seed;
    bit            bp;
    logic [AW-1:0] a0, a4, a15;
    logic [DW-1:0] d0, d15;
    int            ticks;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cap = 1'b0;
  logic [AW-1:0] base = '0;
  logic [DW-1:0] b [16];
  logic          clr_ovf = 1'b0;
  logic          st_done, busy, full, ovf;

  always #5 clk = ~clk;

  lvg_store_if #(.DW(DW), .AW(AW)) wr_if ();

  lvg_store #(.DW(DW), .AW(AW), .ROW_STRIDE(RS)) dut (
    .i_clk(clk), .i_rst(rst), .i_cap(cap), .i_base(base),
    .i_b11(b[0]),  .i_b12(b[1]),  .i_b13(b[2]),  .i_b14(b[3]),
    .i_b21(b[4]),  .i_b22(b[5]),  .i_b23(b[6]),  .i_b24(b[7]),
    .i_b31(b[8]),  .i_b32(b[9]),  .i_b33(b[10]), .i_b34(b[11]),
    .i_b41(b[12]), .i_b42(b[13]), .i_b43(b[14]), .i_b44(b[15]),
    .i_clr_ovf(clr_ovf), .wr(wr_if),
    .o_st_done(st_done), .o_busy(busy), .o_full(full), .o_ovf(ovf)
  );

  int checks = 0;
  int failures = 0;
  int gcyc = 0;

  // Reference model: a queue of expected beats plus a count of matrices
  // still owed to memory (at most two can be held).
  beat_t q[$];
  int    pend = 0;
  bit    m_ovf = 1'b0;
  bit    exp_done;

  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  int            obs_t[$];
  int            done_t[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, gcyc);
    end
  endtask

  task automatic set_mat(input logic [DW-1:0] seed);
    for (int k = 0; k < 16; k++) b[k] = seed + DW'(16 * (k / 4 + 1) + (k % 4 + 1));
  endtask

  task automatic push_model();
    beat_t bt;
    for (int k = 0; k < 16; k++) begin
      bt.addr = base + AW'(RS * (k / 4) + 4 * (k % 4));
      bt.data = b[k];
      bt.last = (k == 15);
      q.push_back(bt);
    end
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); obs_t.delete(); done_t.delete();
  endtask

  // Called at a falling edge with inputs already applied: checks the port,
  // advances the model across the next rising edge, then checks status.
  task automatic tick();
    bit    hs, drop;
    beat_t bt;
    chk("wr_valid", wr_if.wr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("wr_addr", wr_if.wr_addr, q[0].addr);
      chk("wr_data", wr_if.wr_data, q[0].data);
    end
    if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
      obs_a.push_back(wr_if.wr_addr);
      obs_d.push_back(wr_if.wr_data);
      obs_t.push_back(gcyc);
    end
    hs       = (q.size() != 0) && (wr_if.wr_ready === 1'b1);
    drop     = cap && (pend == 2);
    exp_done = 1'b0;
    if (hs) begin
      bt = q.pop_front();
      if (bt.last) begin
        pend--;
        exp_done = 1'b1;
      end
    end
    if (cap && !drop) begin
      push_model();
      pend++;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    gcyc++;
    chk("st_done", st_done, exp_done);
    chk("busy", busy, pend > 0);
    chk("full", full, pend == 2);
    chk("ovf", ovf, m_ovf);
    if (st_done === 1'b1) done_t.push_back(gcyc);
  endtask

  vec_t vec [5];

  initial begin
    int got_ticks;
    int found;

    vec[0] = '{16'h0100, 32'h0000_0000, 1'b0, 16'h0100, 16'h0110, 16'h013C, 32'h0000_0011, 32'h0000_0044, 16};
    vec[1] = '{16'h0100, 32'hA000_0000, 1'b1, 16'h0100, 16'h0110, 16'h013C, 32'hA000_0011, 32'hA000_0044, 32};
    vec[2] = '{16'hFFF0, 32'h0000_0500, 1'b0, 16'hFFF0, 16'h0000, 16'h002C, 32'h0000_0511, 32'h0000_0544, 16};
    vec[3] = '{16'hFFFC, 32'hFFFF_FF00, 1'b1, 16'hFFFC, 16'h000C, 16'h0038, 32'hFFFF_FF11, 32'hFFFF_FF44, 32};
    vec[4] = '{16'h1234, 32'h0000_0001, 1'b0, 16'h1234, 16'h1244, 16'h1270, 32'h0000_0012, 32'h0000_0045, 16};

    for (int k = 0; k < 16; k++) b[k] = '0;
    wr_if.wr_ready = 1'b0;

    // Reset values while reset is held.
    #1;
    chk("rst0_valid", wr_if.wr_valid, 1'b0);
    chk("rst0_addr", wr_if.wr_addr, 16'h0000);
    chk("rst0_data", wr_if.wr_data, 32'h0);
    chk("rst0_st_done", st_done, 1'b0);
    chk("rst0_busy", busy, 1'b0);
    chk("rst0_full", full, 1'b0);
    chk("rst0_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table: single captures, ready high or toggling 1,0,0,1, incl. address wrap.
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      base = vec[i].base;
      set_mat(vec[i].seed);
      cap = 1'b1;
      wr_if.wr_ready = 1'b0;
      tick();
      cap = 1'b0;
      got_ticks = -1;
      for (int t = 0; t < 64 && got_ticks < 0; t++) begin
        wr_if.wr_ready = vec[i].bp ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
        tick();
        if (st_done === 1'b1) got_ticks = t + 1;
      end
      chk("vec_ticks", got_ticks, vec[i].ticks);
      chk("vec_beats", obs_a.size(), 16);
      if (obs_a.size() == 16) begin
        chk("vec_a0", obs_a[0], vec[i].a0);
        chk("vec_a4", obs_a[4], vec[i].a4);
        chk("vec_a15", obs_a[15], vec[i].a15);
        chk("vec_d0", obs_d[0], vec[i].d0);
        chk("vec_d15", obs_d[15], vec[i].d15);
      end
      for (int t = 0; t < 3; t++) tick();
    end

    // Ping-pong: second capture while beat 5 of the first is on the port.
    clear_obs();
    wr_if.wr_ready = 1'b1;
    base = 16'h0100; set_mat(32'h0); cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int t = 0; t < 20 && obs_a.size() < 5; t++) tick();
    base = 16'h0200; set_mat(32'h1000_0000); cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int t = 0; t < 60 && done_t.size() < 2; t++) tick();
    chk("pp_done_count", done_t.size(), 2);
    if (done_t.size() == 2) chk("pp_done_gap", done_t[1] - done_t[0], 16);
    chk("pp_beats", obs_a.size(), 32);
    if (obs_a.size() == 32) begin
      chk("pp_no_bubble", obs_t[16] - obs_t[15], 1);
      chk("pp_2nd_addr", obs_a[16], 16'h0200);
      chk("pp_2nd_data", obs_d[16], 32'h1000_0011);
    end

    // Overflow: three captures with memory stalled; third dropped even with clr_ovf.
    clear_obs();
    wr_if.wr_ready = 1'b0;
    base = 16'h0300; set_mat(32'h2000_0000); cap = 1'b1;
    tick();
    base = 16'h0400; set_mat(32'h3000_0000);
    tick();
    chk("ovf_full", full, 1'b1);
    base = 16'h0500;
    for (int k = 0; k < 16; k++) b[k] = 32'hDEAD_0000 | k;
    clr_ovf = 1'b1;
    tick();
    chk("ovf_set_wins", ovf, 1'b1);
    cap = 1'b0;
    tick();
    chk("ovf_cleared", ovf, 1'b0);
    clr_ovf = 1'b0;
    wr_if.wr_ready = 1'b1;
    for (int t = 0; t < 40; t++) tick();
    chk("ovf_beats", obs_a.size(), 32);
    found = 0;
    foreach (obs_d[j]) if (obs_d[j][31:16] == 16'hDEAD) found++;
    chk("ovf_dropped_absent", found, 0);

    // Reset mid-drain with ovf set.
    wr_if.wr_ready = 1'b0;
    cap = 1'b1;
    base = 16'h0600; set_mat(32'h5000_0000); tick();
    base = 16'h0700; tick();
    base = 16'h0800; tick();
    cap = 1'b0;
    clear_obs();
    wr_if.wr_ready = 1'b1;
    for (int t = 0; t < 20 && obs_a.size() < 7; t++) tick();
    #2 rst = 1'b0;
    #1;
    chk("rstmid_valid", wr_if.wr_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_full", full, 1'b0);
    chk("rstmid_ovf", ovf, 1'b0);
    chk("rstmid_st_done", st_done, 1'b0);
    q.delete(); pend = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    clear_obs();
    base = 16'h0900; set_mat(32'h4000_0000); cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    chk("rstmid_beats", obs_a.size(), 16);
    chk("rstmid_done_count", done_t.size(), 1);
    if (obs_a.size() == 16) begin
      chk("rstmid_a0", obs_a[0], 16'h0900);
      chk("rstmid_d0", obs_d[0], 32'h4000_0011);
      chk("rstmid_a15", obs_a[15], 16'h093C);
    end

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      cap = ($urandom_range(0, 3) == 0);
      if (cap) begin
        base = AW'($urandom);
        for (int k = 0; k < 16; k++) b[k] = $urandom;
      end
      clr_ovf = ($urandom_range(0, 15) == 0);
      wr_if.wr_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    cap = 1'b0;
    clr_ovf = 1'b0;
    wr_if.wr_ready = 1'b1;
    for (int t = 0; t < 40; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvg_store.md
# lvg_store

Writeback stage directly downstream of the lvg matrix unit. When the controller strobes a capture, the block snapshots the 4x4 result matrix (b11..b44) together with a destination base address into one of two ping-pong banks. It then streams the 16 words row-major over a valid/ready memory write port. Holding two banks lets the next matrix operation complete while the previous result is still draining.

## Interface
- DW, default 32: result and write-data word width.
- AW, default 16: byte address width.
- ROW_STRIDE, default 16: byte distance between consecutive matrix rows in memory.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset).
- cap, input, 1: capture strobe; samples b11..b44 and base on the same edge.
- base, input, AW: byte address of element (1,1) for this capture.
- b11..b44, input, DW each: the 16 lvg result words.
- clr_ovf, input, 1: synchronous clear of ovf.
- wr_valid, output, 1: write beat valid.
- wr_ready, input, 1: memory accepts the beat.
- wr_addr, output, AW: byte address of the current beat.
- wr_data, output, DW: data of the current beat.
- st_done, output, 1: one-cycle pulse after the 16th beat of a bank is accepted.
- busy, output, 1: at least one bank is full or draining.
- full, output, 1: both banks are occupied; a cap now is dropped.
- ovf, output, 1: sticky; set when a cap is dropped.

## Operation
- Storage and pointers:
  - Two banks, each holding 16 words plus a latched base address.
  - Per-bank occupied flag.
  - Write pointer wp selects the bank that captures next; read pointer rp selects the bank that is draining.
- Capture:
  - On cap with the wp bank free, before the edge: store all 16 words and base, set occupied, toggle wp.
  - On cap with both banks occupied before the edge: drop the capture, set ovf, leave all state unchanged. This applies even if a bank frees on that same edge.
- Drain FSM states:
  - IDLE: wr_valid=0. Move to DRAIN when the rp bank is occupied.
  - DRAIN: beat index k runs 0..15. Row r=k[3:2], column c=k[1:0].
  - Beat order is row-major: b11, b12, b13, b14, b21, …, b44.
  - wr_data = word(r,c).
  - wr_addr = base + r*ROW_STRIDE + c*4, modulo 2^AW; wrap-around is silent.
  - On handshake (wr_valid & wr_ready), k increments.
  - On the handshake with k=15: clear the bank's occupied flag, toggle rp, pulse st_done, reset k to 0.
  - After k=15: stay in DRAIN if the other bank is occupied, else go to IDLE.
- Handshake rules:
  - While wr_valid=1 and no handshake occurs, wr_addr and wr_data hold stable.
  - wr_valid never drops before the beat is accepted.
- Status outputs:
  - busy = either bank occupied.
  - full = both banks occupied.
- ovf: clr_ovf clears it. If clr_ovf and a dropped cap occur on the same edge, set wins.
- Reset (any time, including mid-drain):
  - Clears both occupied flags, wp, rp, k and ovf; FSM returns to IDLE.
  - Partially written data is abandoned and no st_done is issued for it.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, st_done=0, busy=0, full=0, ovf=0.
- All outputs are registered or derived from registers only; no combinational path from wr_ready or cap to any output.
- Capture latency: cap sampled at edge N, then busy=1 and wr_valid=1 with beat 0 on the port after edge N (drain from IDLE starts on the following edge at latest: wr_valid by edge N+1).
- Throughput: with wr_ready held high, one beat per cycle, so 16 cycles per matrix.
- There is no bubble between banks when the second bank is already occupied.
- st_done is asserted in the cycle after the final handshake edge, for exactly one cycle.
- Back-to-back caps on consecutive cycles with both banks free are both accepted.

## Structure
- Shared package holds:
  - the FSM state encoding (ST_IDLE, ST_DRAIN);
  - the matrix dimension constant MAT_N=4 and derived beat count 16;
  - the word byte size 4.
- One sub-module is natural: lvg_store_bank, a single 16-word bank with capture port, base register and a 4-bit indexed read mux. It is instantiated twice.
- FSM, pointers and address generation live in the top module.

## Test plan
- Single capture, ready always high: cap with base=0x0100 and bij=0x10*i+j. Expect beats 0x11, 0x12 … 0x44 at addresses 0x0100, 0x0104, 0x0108, 0x010C, 0x0110 … 0x013C on 16 consecutive cycles, st_done once, then busy=0.
- Backpressure: wr_ready toggles 1,0,0,1 repeatedly. Expect wr_addr and wr_data stable while not ready, exactly 16 handshakes, and the order unchanged.
- Ping-pong: second cap (base=0x0200) during the first drain at beat 5. Expect the second matrix to start the cycle after beat 15 with no bubble, and two st_done pulses 16 cycles apart.
- Overflow: three caps while wr_ready=0. Expect full=1 after the second, ovf=1 after the third, and the third data never appearing. Then clr_ovf gives ovf=0.
- Address wrap: AW=16, base=0xFFF0. Expect row 1 at 0x0000 and the last beat at 0x002C.
- Reset mid-drain: rst low at beat 7. Expect wr_valid=0, busy=0, ovf=0 immediately (asynchronously), no st_done, and a clean 16-beat drain from beat 0 on the next cap.
